smart_house_load_scheduler: RTL and testbench



---
 rtl/smart_house_load_scheduler.sv | 104 ++++++++++
 tb/tb_smart_house_load_scheduler.sv | 137 +++++++++++++
 2 files changed

// File: rtl/smart_house_load_scheduler.sv
// Power-budget arbiter for the house appliances: admits at most one request per
// clock, round-robin, keeping the granted cost within BUDGET and enforcing a minimum on-time.
module smart_house_load_scheduler #(
  parameter int BUDGET      = 8,
  parameter int COST_LIGHT  = 1,
  parameter int COST_MUSIC  = 2,
  parameter int COST_COOLER = 5,
  parameter int COST_HEATER = 5,
  parameter int MIN_ON      = 16,
  parameter int TW          = 5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [7:0] power_used,
  output logic [3:0] waiting
);

  logic [3:0]    r_grant;
  logic [1:0]    r_ptr;
  logic [7:0]    r_power;
  logic [TW-1:0] r_timer [4];

  logic [3:0] w_grel;
  logic [7:0] w_prel;
  logic [3:0] w_cand;
  logic       w_admit;
  logic [1:0] w_idx;
  logic [3:0] w_grant_nxt;

  function automatic logic [7:0] f_cost(input logic [1:0] i);
    case (i)
      2'd0:    f_cost = 8'(COST_LIGHT);
      2'd1:    f_cost = 8'(COST_MUSIC);
      2'd2:    f_cost = 8'(COST_COOLER);
      default: f_cost = 8'(COST_HEATER);
    endcase
  endfunction

  function automatic logic [7:0] f_sum(input logic [3:0] g);
    f_sum = 8'd0;
    for (int i = 0; i < 4; i++)
      if (g[i]) f_sum = f_sum + f_cost(2'(i));
  endfunction

  // Release phase: a grant only drops once its request is gone and min-on has elapsed
  always_comb begin
    w_grel = r_grant;
    for (int i = 0; i < 4; i++)
      if (r_grant[i] && !req[i] && (r_timer[i] == '0)) w_grel[i] = 1'b0;
  end

  assign w_prel = f_sum(w_grel);

  // Admit phase candidates; the budget compare is one bit wider so no cost can wrap
  always_comb begin
    w_cand = 4'b0000;
    for (int i = 0; i < 4; i++)
      w_cand[i] = req[i] && !w_grel[i] &&
                  (({1'b0, w_prel} + {1'b0, f_cost(2'(i))}) <= 9'(BUDGET));
    if (w_grel[3]) w_cand[2] = 1'b0;
    if (w_grel[2]) w_cand[3] = 1'b0;
  end

  always_comb begin
    w_admit = 1'b0;
    w_idx   = r_ptr;
    for (int k = 0; k < 4; k++) begin
      if (!w_admit && w_cand[r_ptr + 2'(k)]) begin
        w_admit = 1'b1;
        w_idx   = r_ptr + 2'(k);
      end
    end
  end

  assign w_grant_nxt = w_grel | (w_admit ? (4'b0001 << w_idx) : 4'b0000);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_grant <= 4'b0000;
      r_ptr   <= 2'd0;
      r_power <= 8'd0;
      for (int i = 0; i < 4; i++) r_timer[i] <= '0;
    end else begin
      r_grant <= w_grant_nxt;
      r_power <= f_sum(w_grant_nxt);
      if (w_admit) r_ptr <= w_idx + 2'd1;
      for (int i = 0; i < 4; i++) begin
        if (w_admit && (w_idx == 2'(i)))
          r_timer[i] <= TW'(MIN_ON - 1);
        else if (w_grel[i] && (r_timer[i] != '0))
          r_timer[i] <= r_timer[i] - 1'b1;
        else if (!w_grel[i])
          r_timer[i] <= '0;
      end
    end
  end

  assign grant      = r_grant;
  assign power_used = r_power;
  assign waiting    = req & ~r_grant;

endmodule

// File: tb/tb_smart_house_load_scheduler.sv
// Directed bench for smart_house_load_scheduler with default parameters.
module tb_smart_house_load_scheduler;

  logic       clock;
  logic       reset;
  logic [3:0] req;
  logic [3:0] grant;
  logic [7:0] power_used;
  logic [3:0] waiting;

  int vectors;
  int miscompares;

  smart_house_load_scheduler dut (
    .clock      (clock),
    .reset      (reset),
    .req        (req),
    .grant      (grant),
    .power_used (power_used),
    .waiting    (waiting)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_reset;
    #2 reset = 1'b0;
    #2 reset = 1'b1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    req         = 4'b0000;

    #12;
    chk("rst_grant", {4'b0, grant}, 8'h00);
    chk("rst_power", power_used, 8'd0);
    req = 4'b1111;
    step;
    chk("rst_hold_grant", {4'b0, grant}, 8'h00);
    chk("rst_waiting", {4'b0, waiting}, 8'h0F);
    #2 reset = 1'b1;

    // Full request from reset: light, music, cooler; heater blocked
    step;
    chk("all_e1_grant", {4'b0, grant}, 8'h01);
    chk("all_e1_power", power_used, 8'd1);
    step;
    chk("all_e2_grant", {4'b0, grant}, 8'h03);
    chk("all_e2_power", power_used, 8'd3);
    step;
    chk("all_e3_grant", {4'b0, grant}, 8'h07);
    chk("all_e3_power", power_used, 8'd8);
    chk("all_e3_waiting", {4'b0, waiting}, 8'h08);

    // Cooler request dropped right after admission: held by min-on for 15 more edges
    req = 4'b1011;
    for (int i = 0; i < 15; i++) begin
      step;
      chk("cool_minon_grant", {4'b0, grant}, 8'h07);
    end
    step;
    chk("heat_swap_grant", {4'b0, grant}, 8'h0B);
    chk("heat_swap_power", power_used, 8'd8);
    step;
    chk("heat_hold_grant", {4'b0, grant}, 8'h0B);
    chk("heat_hold_waiting", {4'b0, waiting}, 8'h00);

    // One-cycle light pulse from idle
    req = 4'b0000;
    pulse_reset;
    chk("idle_grant", {4'b0, grant}, 8'h00);
    req = 4'b0001;
    step;
    req = 4'b0000;
    chk("pulse_c1_grant", {4'b0, grant}, 8'h01);
    chk("pulse_c1_power", power_used, 8'd1);
    for (int i = 0; i < 15; i++) begin
      step;
      chk("pulse_hold_grant", {4'b0, grant}, 8'h01);
    end
    step;
    chk("pulse_end_grant", {4'b0, grant}, 8'h00);
    chk("pulse_end_power", power_used, 8'd0);

    // Cooler and heater together from reset
    pulse_reset;
    req = 4'b1100;
    step;
    chk("ch_e1_grant", {4'b0, grant}, 8'h04);
    chk("ch_e1_power", power_used, 8'd5);
    for (int i = 0; i < 3; i++) begin
      step;
      chk("ch_hold_grant", {4'b0, grant}, 8'h04);
      chk("ch_heat_waiting", {4'b0, waiting}, 8'h08);
    end

    // ptr is 3: light then music join the cooler
    req = 4'b0111;
    step;
    chk("lm_e1_grant", {4'b0, grant}, 8'h05);
    chk("lm_e1_power", power_used, 8'd6);
    step;
    chk("lm_e2_grant", {4'b0, grant}, 8'h07);
    chk("lm_e2_power", power_used, 8'd8);

    // Asynchronous reset in mid-cycle
    #3 reset = 1'b0;
    #1;
    chk("async_grant", {4'b0, grant}, 8'h00);
    chk("async_power", power_used, 8'd0);
    #1 reset = 1'b1;
    req = 4'b1111;
    step;
    chk("post_rst_grant", {4'b0, grant}, 8'h01);
    chk("post_rst_power", power_used, 8'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
